// File: rtl/delay_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_align_pkg
// Description : Shared definitions for the two-channel skew compensator:
//               alignment state encoding and the maximum correctable skew
//               derived from the skew counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_align_pkg;

    // Alignment FSM states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ALIGNED = 2'd2
    } state_t;

    // Largest skew a counter/pointer of the given width can correct.
    function automatic int max_skew_of(input int skew_width);
        return (1 << skew_width) - 1;
    endfunction

endpackage : delay_align_pkg
`default_nettype wire

// File: rtl/delay_ring.sv
`default_nettype none
// ============================================================================
// Module      : delay_ring
// Description : Ring buffer with one synchronous write port and one
//               asynchronous addressed read port. Written every cycle; the
//               owner supplies the write pointer and the read address.
// Ports       : clk        - system clock
//               i_wr_addr  - write address (shared write pointer)
//               i_wr_data  - word written this cycle
//               i_rd_addr  - read address
//               o_rd_data  - word stored at i_rd_addr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module delay_ring #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Contents are intentionally not reset: every word is rewritten before
    // it can be read back by an aligned channel.
    logic [WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : delay_ring
`default_nettype wire

// File: rtl/delay_align.sv
`default_nettype none
// ============================================================================
// Module      : delay_align
// Description : Two-channel skew compensator. Measures the arrival skew of
//               periodic frame markers on channels A and B, then delays the
//               early channel through a ring buffer so both channels leave
//               aligned. Continuously checks that the markers stay aligned
//               and drops lock on the first mismatch.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               din_a/mark_a      - channel A sample and frame marker
//               din_b/mark_b      - channel B sample and frame marker
//               dout_a/dout_b     - aligned outputs (registered)
//               dvalid, locked    - high while aligned
//               skew              - measured skew in cycles
//               early_b           - B is the delayed (early) channel
//               align_err         - one-cycle pulse on timeout / lock loss
// Revision    : 1.0 - initial release
// ============================================================================
module delay_align
    import delay_align_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SKEW_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic                  mark_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  mark_b,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  dvalid,
    output logic                  locked,
    output logic [SKEW_WIDTH-1:0] skew,
    output logic                  early_b,
    output logic                  align_err
);

    localparam logic [SKEW_WIDTH-1:0] c_MAX_SKEW = SKEW_WIDTH'(max_skew_of(SKEW_WIDTH));
    localparam int                    c_RING_W   = DATA_WIDTH + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SKEW_WIDTH-1:0] r_wr_ptr;
    logic [SKEW_WIDTH-1:0] r_cnt;
    logic [SKEW_WIDTH-1:0] w_cnt_nxt;
    logic [SKEW_WIDTH-1:0] r_skew;
    logic [SKEW_WIDTH-1:0] w_skew_nxt;
    logic [SKEW_WIDTH-1:0] w_skew_sel;
    logic [SKEW_WIDTH-1:0] w_rd_addr;
    logic                  r_first_b;
    logic                  w_first_b_nxt;
    logic                  r_early_b;
    logic                  w_early_b_nxt;
    logic                  w_early_sel;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] r_dout_a;
    logic [DATA_WIDTH-1:0] r_dout_b;
    logic [c_RING_W-1:0]   w_ring_a;
    logic [c_RING_W-1:0]   w_ring_b;
    logic [c_RING_W-1:0]   w_early_cur;
    logic [c_RING_W-1:0]   w_early_dly;
    logic                  w_both;
    logic                  w_mark_first;
    logic                  w_mark_other;
    logic                  w_mark_late;

    assign w_both       = mark_a & mark_b;
    assign w_mark_first = r_first_b ? mark_b : mark_a;
    assign w_mark_other = r_first_b ? mark_a : mark_b;

    // ------------------------------------------------------------------
    // Skew/early-channel selection for the read path. Derived from
    // registered state only, so the read path has the right delay on the
    // locking edge itself without depending on the next-state logic.
    // In WAIT, a lock on the other channel's marker yields skew cnt+1.
    // ------------------------------------------------------------------
    always_comb begin
        w_skew_sel  = '0;
        w_early_sel = 1'b0;
        if (r_state == ST_ALIGNED) begin
            w_skew_sel  = r_skew;
            w_early_sel = r_early_b;
        end else if ((r_state == ST_WAIT) && !w_both) begin
            w_skew_sel  = r_cnt + 1'b1;
            w_early_sel = r_first_b;
        end
    end

    assign w_rd_addr = r_wr_ptr - w_skew_sel;

    delay_ring #(
        .WIDTH      (c_RING_W),
        .ADDR_WIDTH (SKEW_WIDTH)
    ) u_ring_a (
        .clk       (clk),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({mark_a, din_a}),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ring_a)
    );

    delay_ring #(
        .WIDTH      (c_RING_W),
        .ADDR_WIDTH (SKEW_WIDTH)
    ) u_ring_b (
        .clk       (clk),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({mark_b, din_b}),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ring_b)
    );

    // Zero skew bypasses the ring: the slot at wr_ptr is only being
    // written this cycle and still holds a 16-cycle-old word.
    assign w_early_cur = w_early_sel ? {mark_b, din_b} : {mark_a, din_a};
    assign w_early_dly = (w_skew_sel == '0) ? w_early_cur
                                            : (w_early_sel ? w_ring_b : w_ring_a);
    assign w_mark_late = w_early_sel ? mark_a : mark_b;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_first_b_nxt = r_first_b;
        w_skew_nxt    = r_skew;
        w_early_b_nxt = r_early_b;
        w_err_nxt     = 1'b0;
        w_load        = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                if (w_both) begin
                    w_skew_nxt    = '0;
                    w_early_b_nxt = 1'b0;
                    w_state_nxt   = ST_ALIGNED;
                    w_load        = 1'b1;
                end else if (mark_a || mark_b) begin
                    w_first_b_nxt = mark_b;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // cnt == MAX means the other marker would be MAX+1 cycles
                // late, beyond what the ring can hold: give up first.
                if (r_cnt == c_MAX_SKEW) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else if (w_both) begin
                    w_skew_nxt    = '0;
                    w_early_b_nxt = 1'b0;
                    w_state_nxt   = ST_ALIGNED;
                    w_load        = 1'b1;
                end else if (w_mark_other) begin
                    w_skew_nxt    = w_skew_sel;
                    w_early_b_nxt = w_early_sel;
                    w_state_nxt   = ST_ALIGNED;
                    w_load        = 1'b1;
                end else if (w_mark_first) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_ALIGNED: begin
                if (w_early_dly[DATA_WIDTH] != w_mark_late) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_load = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters, measured skew and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_first_b <= 1'b0;
            r_skew    <= '0;
            r_early_b <= 1'b0;
            r_err     <= 1'b0;
            r_dout_a  <= '0;
            r_dout_b  <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_cnt     <= w_cnt_nxt;
            r_first_b <= w_first_b_nxt;
            r_skew    <= w_skew_nxt;
            r_early_b <= w_early_b_nxt;
            r_err     <= w_err_nxt;
            // Outputs hold whenever the next cycle is not aligned.
            if (w_load) begin
                if (w_early_sel) begin
                    r_dout_b <= w_early_dly[DATA_WIDTH-1:0];
                    r_dout_a <= din_a;
                end else begin
                    r_dout_a <= w_early_dly[DATA_WIDTH-1:0];
                    r_dout_b <= din_b;
                end
            end
        end
    end

    assign dout_a    = r_dout_a;
    assign dout_b    = r_dout_b;
    assign locked    = (r_state == ST_ALIGNED);
    assign dvalid    = (r_state == ST_ALIGNED);
    assign skew      = r_skew;
    assign early_b   = r_early_b;
    assign align_err = r_err;

endmodule : delay_align
`default_nettype wire
